// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
// Instruction-fetch stage sitting directly upstream of the control unit.
// It owns the program counter, fetches one instruction word at a time over a
// req/ack handshake, holds the returned word on instr until downstream takes
// it, and then steps the PC using the branch decision returned for that word.
//
// Ports
//   clk          system clock, all state on the rising edge
//   rst          asynchronous active-high reset
//   imem_req     fetch request to instruction memory (high only in REQ)
//   imem_addr    fetch address, always equal to PC
//   imem_ack     memory presents imem_rdata this cycle
//   imem_rdata   fetched instruction word
//   instr        held instruction, NOP_INSTR whenever nothing valid is held
//   instr_valid  instr is valid (high only in HOLD)
//   instr_ready  downstream consumes instr this cycle
//   PCsrc        branch taken for the instruction being consumed
//   ImmOp        sign-extended branch offset for that instruction
//   PC           address of the current / held instruction
//   fault        sticky flag: a misaligned next PC was produced
//   fetch_count  number of instructions consumed (wraps)
//
// Every output is a register or a decode of the state register, so there is
// no combinational path from instr_ready / PCsrc / ImmOp to any output.

module pc_fetch_unit #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter logic [31:0]           NOP_INSTR  = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_ack,
    input  logic [31:0]           imem_rdata,
    output logic [31:0]           instr,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    input  logic                  PCsrc,
    input  logic [ADDR_WIDTH-1:0] ImmOp,
    output logic [ADDR_WIDTH-1:0] PC,
    output logic                  fault,
    output logic [31:0]           fetch_count
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        REQ   = 2'd1,
        HOLD  = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [31:0]           instr_q, instr_d;
    logic                  fault_q, fault_d;
    logic [31:0]           count_q, count_d;
    logic [ADDR_WIDTH-1:0] next_pc;

    // Two's-complement addition is sign-agnostic, so a negative ImmOp simply
    // wraps modulo 2^ADDR_WIDTH; no overflow is flagged.
    function automatic logic [ADDR_WIDTH-1:0] step_pc(
        input logic [ADDR_WIDTH-1:0] pc,
        input logic                  taken,
        input logic [ADDR_WIDTH-1:0] imm
    );
        logic signed [ADDR_WIDTH-1:0] imm_s;
        imm_s = imm;
        if (taken)
            return pc + imm_s;
        else
            return pc + ADDR_WIDTH'(4);
    endfunction

    // Only meaningful in HOLD; the FSM ignores it in every other state.
    assign next_pc = step_pc(pc_q, PCsrc, ImmOp);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            fault_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            fault_q <= fault_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        fault_d = fault_q;
        count_d = count_q;
        case (state_q)
            // One idle cycle after reset; a late ack from before reset lands
            // here and is dropped.
            BOOT: state_d = REQ;
            REQ: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (instr_ready) begin
                    count_d = count_q + 32'd1;
                    instr_d = NOP_INSTR;
                    pc_d    = next_pc;
                    if (next_pc[1:0] != 2'b00) begin
                        fault_d = 1'b1;
                        state_d = FAULT;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            // Terminal until reset; PC keeps the offending address.
            FAULT: state_d = FAULT;
            default: state_d = BOOT;
        endcase
    end

    assign imem_req    = (state_q == REQ);
    assign instr_valid = (state_q == HOLD);
    assign imem_addr   = pc_q;
    assign PC          = pc_q;
    assign instr       = instr_q;
    assign fault       = fault_q;
    assign fetch_count = count_q;

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the control unit.
- Owns the program counter and issues word fetches to instruction memory over a req/ack handshake.
- Holds each returned instruction stable on instr until downstream accepts it.
- On acceptance, computes the next PC from the branch decision (PCsrc, ImmOp) returned for that instruction.

Parameters:
- ADDR_WIDTH, 32, width of PC and imem_addr.
- RESET_PC, 32'h00000000, PC value loaded on reset.
- NOP_INSTR, 32'h00000013, value driven on instr while no valid instruction is held (addi x0,x0,0).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  ADDR_WIDTH  word-aligned fetch address (= PC).
- imem_ack  input  1  memory returns imem_rdata this cycle.
- imem_rdata  input  32  fetched instruction word.
- instr  output  32  held instruction to control unit / datapath.
- instr_valid  output  1  instr is valid.
- instr_ready  input  1  downstream consumes instr this cycle.
- PCsrc  input  1  branch taken for the instruction being consumed.
- ImmOp  input  ADDR_WIDTH  sign-extended branch offset for that instruction.
- PC  output  ADDR_WIDTH  address of the current/held instruction.
- fault  output  1  misaligned next-PC detected; sticky.
- fetch_count  output  32  count of instructions consumed.

Behaviour:
- Reset (async, immediate):
  - State BOOT; PC=RESET_PC.
  - imem_req=0, instr=NOP_INSTR, instr_valid=0, fault=0, fetch_count=0.
- State machine: BOOT, REQ, HOLD, FAULT.
- BOOT:
  - Outputs idle for exactly one cycle after rst deasserts, then REQ.
  - imem_ack is ignored.
- REQ:
  - imem_req=1; imem_addr=PC, stable until ack.
  - On imem_ack, imem_rdata is captured into instr; next cycle instr_valid=1, imem_req=0, state HOLD.
  - Ack may arrive in the same cycle as req is first asserted (zero wait). Minimum latency is req in cycle N, instr_valid in N+1.
  - With no ack, stay in REQ indefinitely.
- HOLD:
  - instr and PC are stable; instr_valid=1.
  - PCsrc and ImmOp are sampled only in a cycle where instr_valid && instr_ready; they are ignored otherwise.
  - On consume:
    - next_pc = PCsrc ? PC + ImmOp : PC + 4, both modulo 2^ADDR_WIDTH (wrap, no flag).
    - fetch_count increments, wrapping at 2^32.
    - Next cycle: instr_valid=0, instr=NOP_INSTR.
    - If next_pc[1:0] == 0: PC=next_pc, state REQ.
    - If next_pc[1:0] != 0: PC=next_pc, fault=1, state FAULT.
- Throughput: one instruction per 2 cycles with zero-wait memory and instr_ready tied high.
- FAULT:
  - imem_req=0, instr_valid=0, fault=1.
  - PC holds the offending address.
  - Leaves only on rst.
- imem_ack outside REQ: ignored; no state change.
- instr_ready outside HOLD: ignored.
- Reset mid-REQ: request drops asynchronously. A late ack after reset lands in BOOT and is discarded. The first post-reset request is to RESET_PC.
- Outputs instr, instr_valid, imem_req and PC are registered or derived only from state; no combinational path from instr_ready/PCsrc/ImmOp to any output.

Test Plan:
- Reset then zero-wait memory (ack same cycle as req, rdata=32'h00500093), instr_ready=1, PCsrc=0:
  - imem_addr sequence 0x0, 0x4, 0x8.
  - instr_valid pulses every 2nd cycle.
  - fetch_count=3 after three consumes.
- Memory ack delayed 3 cycles:
  - imem_req high and imem_addr=0x0 stable for 4 cycles.
  - instr_valid 1 cycle after ack; instr=captured word.
- Backpressure: instr_ready=0 for 5 cycles in HOLD with PCsrc toggling:
  - instr, PC and instr_valid unchanged; no new request.
  - Consume with PCsrc=0 gives next address PC+4.
- Branch from PC=0x10:
  - PCsrc=1, ImmOp=32'hFFFFFFF8 at consume → next imem_addr=0x08.
  - ImmOp=32'h00000010 → 0x20.
- PC=0xFFFFFFFC, PCsrc=0 → PC wraps to 0x00000000, no fault.
- Misaligned branch: PC=0x10, PCsrc=1, ImmOp=0x6:
  - PC=0x16, fault=1, imem_req stays 0.
  - Assert rst mid-REQ (including during pending ack) → fault=0, PC=RESET_PC, late ack discarded.
